// File: rtl/nes_pkg.sv
// Shared constants, button indices and scan FSM encoding for the NES/SNES pad scanner.
// Pure declarations: no latency, no flow control.
package nes_pkg;

   localparam int NES_BITS = 8;

   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LATCH,
      ST_LOW,
      ST_HIGH,
      ST_COMMIT
   } scan_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/nes_repeat_ctr.sv
// Per-button press/auto-repeat tracker, updated once per commit; press is a registered 1-cycle pulse.
// No backpressure: the consumer must take the pulse in the cycle it appears.
module nes_repeat_ctr
   import nes_pkg::*;
#(
   parameter int REPEAT_DELAY = 30,
   parameter int REPEAT_RATE  = 6
) (
   input  logic clk,
   input  logic reset_n,
   input  logic commit,
   input  logic pressed,
   output logic press
);

   localparam int            CW       = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);
   localparam logic [CW-1:0] DELAY_LD = CW'(REPEAT_DELAY);
   localparam logic [CW-1:0] RATE_LD  = CW'(REPEAT_RATE);
   localparam logic [CW-1:0] ONE      = CW'(1);

   logic [CW-1:0] cnt_q;
   logic          held_q;

   // A zero count while held means repeat is disabled; it only ever reloads from a pulse.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q  <= '0;
         held_q <= 1'b0;
         press  <= 1'b0;
      end else begin
         press <= 1'b0;
         if (commit) begin
            held_q <= pressed;
            if (!pressed) begin
               cnt_q <= '0;
            end else if (!held_q) begin
               press <= 1'b1;
               cnt_q <= DELAY_LD;
            end else if (cnt_q > ONE) begin
               cnt_q <= cnt_q - ONE;
            end else if (cnt_q == ONE) begin
               press <= 1'b1;
               cnt_q <= RATE_LD;
            end
         end
      end
   end

endmodule

// File: rtl/nes_pad_scanner.sv
// Polls NUM_PADS NES pads on a shared latch/clock; results appear 17*HALF_CYCLES+1 cycles after scan start.
// No backpressure: buttons/press/frame_valid are published once per frame and must be taken as they come.
module nes_pad_scanner
   import nes_pkg::*;
#(
   parameter int NUM_PADS     = 2,
   parameter int HALF_CYCLES  = 152,
   parameter int POLL_CYCLES  = 419583,
   parameter int REPEAT_DELAY = 30,
   parameter int REPEAT_RATE  = 6
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         enable,
   input  logic [NUM_PADS-1:0]          nes_data,
   output logic                         nes_latch,
   output logic                         nes_clk,
   output logic [NES_BITS*NUM_PADS-1:0] buttons,
   output logic [NES_BITS*NUM_PADS-1:0] press,
   output logic                         frame_valid,
   output logic                         busy
);

   localparam int            PW        = $clog2(POLL_CYCLES);
   localparam int            HW        = $clog2(2 * HALF_CYCLES);
   localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
   localparam logic [HW-1:0] HALF_LAST = HW'(HALF_CYCLES - 1);
   localparam logic [HW-1:0] LTCH_LAST = HW'(2 * HALF_CYCLES - 1);

   scan_state_t   state_q, state_d;
   logic [PW-1:0] poll_q;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic [2:0]    bit_q, bit_d;
   logic          poll_tick;
   logic          latch_d, sclk_d, sample_en, commit;

   logic [NUM_PADS-1:0][NES_BITS-1:0] shift_q;
   logic [NES_BITS*NUM_PADS-1:0]      shift_flat;

   assign shift_flat = shift_q;
   assign poll_tick  = (poll_q == POLL_LAST);
   assign busy       = (state_q != ST_IDLE);

   // Free-running frame divider; ticks that find the FSM busy or disabled are simply lost.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         poll_q <= '0;
      end else if (poll_tick) begin
         poll_q <= '0;
      end else begin
         poll_q <= poll_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         hcnt_q  <= '0;
         bit_q   <= '0;
      end else begin
         state_q <= state_d;
         hcnt_q  <= hcnt_d;
         bit_q   <= bit_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q + 1'b1;
      bit_d   = bit_q;
      unique case (state_q)
         ST_IDLE: begin
            hcnt_d = '0;
            if (poll_tick && enable) begin
               state_d = ST_LATCH;
               bit_d   = '0;
            end
         end
         ST_LATCH: begin
            if (hcnt_q == LTCH_LAST) begin
               state_d = ST_LOW;
               hcnt_d  = '0;
            end
         end
         ST_LOW: begin
            if (hcnt_q == HALF_LAST) begin
               hcnt_d  = '0;
               state_d = (bit_q == 3'd7) ? ST_COMMIT : ST_HIGH;
            end
         end
         ST_HIGH: begin
            if (hcnt_q == HALF_LAST) begin
               hcnt_d  = '0;
               state_d = ST_LOW;
               bit_d   = bit_q + 3'd1;
            end
         end
         ST_COMMIT: begin
            state_d = ST_IDLE;
            hcnt_d  = '0;
         end
         default: begin
            state_d = ST_IDLE;
            hcnt_d  = '0;
         end
      endcase
   end

   // Pad strobes are decoded from the next state and flopped, so the pins change on clean edges.
   always_comb begin
      latch_d   = (state_d == ST_LATCH);
      sclk_d    = (state_d == ST_HIGH);
      sample_en = (state_q == ST_LOW) && (hcnt_q == HALF_LAST);
      commit    = (state_q == ST_COMMIT);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         nes_latch   <= 1'b0;
         nes_clk     <= 1'b0;
         frame_valid <= 1'b0;
      end else begin
         nes_latch   <= latch_d;
         nes_clk     <= sclk_d;
         frame_valid <= commit;
      end
   end

   // Pad data is active-low; sample just before the rising shift clock moves it on.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         shift_q <= '0;
      end else if (sample_en) begin
         for (int p = 0; p < NUM_PADS; p++) begin
            shift_q[p][bit_q] <= ~nes_data[p];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         buttons <= '0;
      end else if (commit) begin
         buttons <= shift_flat;
      end
   end

   for (genvar i = 0; i < NES_BITS * NUM_PADS; i++) begin : g_rep
      nes_repeat_ctr #(
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_RATE  (REPEAT_RATE)
      ) u_rep (
         .clk     (clk),
         .reset_n (reset_n),
         .commit  (commit),
         .pressed (shift_flat[i]),
         .press   (press[i])
      );
   end

endmodule
